stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_pkg.sv | 39 +++
 rtl/stopwatch_ctrl_bcd_digit.sv | 41 ++++
 rtl/stopwatch_ctrl.sv | 175 +++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and constants for the stopwatch controller.
// The LAP state only exists when STOPWATCH_LAP_EN is defined.
package stopwatch_pkg;

`ifdef STOPWATCH_LAP_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } sw_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_t;
`endif

    // One BCD digit of the displayed time.
    typedef logic [3:0] bcd_t;

    // Highest value of a decimal digit and of a tens-of-seconds/minutes digit.
    localparam bcd_t DIGIT_MAX_DEC = 4'd9;
    localparam bcd_t DIGIT_MAX_SEX = 4'd5;

    // Six packed BCD digits: {min_t, min_u, sec_t, sec_u, cs_t, cs_u}.
    localparam int TIME_W = 24;

    // True in the states where time advances.
    function automatic logic is_counting(input sw_state_t s);
`ifdef STOPWATCH_LAP_EN
        return (s == ST_RUN) || (s == ST_LAP);
`else
        return (s == ST_RUN);
`endif
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// bcd_digit: one cascadable modulo-(MAX+1) BCD digit with synchronous clear.
// q_next is exported so the parent can register values that change on the
// same edge as the digit itself.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter bcd_t MAX = DIGIT_MAX_DEC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output bcd_t q_next,
    output logic carry
);

    bcd_t q;

    // Carry out when this digit rolls over, feeding the next digit's inc.
    assign carry = inc && !clr && (q == MAX);

    // Next value: clear wins, otherwise count up and wrap at MAX.
    always_comb begin
        q_next = q;
        if (clr) begin
            q_next = '0;
        end else if (inc) begin
            q_next = (q == MAX) ? '0 : q + 4'd1;
        end
    end

    // Digit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: MM:SS.cc stopwatch with start/stop, clear and lap hold.
// Define STOPWATCH_LAP_EN to enable the LAP state and lap register; without
// it lap_p is ignored and lap_active stays low.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 100000000,
    parameter int TICK_HZ = 100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ss_p,
    input  logic              clr_p,
    input  logic              lap_p,
    output logic [TIME_W-1:0] disp_bcd,
    output logic              running,
    output logic              lap_active,
    output logic              ovf
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    sw_state_t         state;
    sw_state_t         state_next;
    logic              zero_all;
    logic              presc_en;
    logic              tick;
    logic [PW-1:0]     presc;
    logic [TIME_W-1:0] count_next;
    logic [TIME_W-1:0] disp_src;
    logic              c_cs_u, c_cs_t, c_sec_u, c_sec_t, c_min_u, c_min_t;
`ifdef STOPWATCH_LAP_EN
    logic              lap_take;
`endif

    // Pulse decode: clr > ss > lap among the pulses legal in each state.
    always_comb begin
        state_next = state;
        zero_all   = 1'b0;
`ifdef STOPWATCH_LAP_EN
        lap_take   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (clr_p) begin
                    zero_all = 1'b1;
                end else if (ss_p) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ss_p) begin
                    state_next = ST_PAUSE;
`ifdef STOPWATCH_LAP_EN
                end else if (lap_p) begin
                    state_next = ST_LAP;
                    lap_take   = 1'b1;
`endif
                end
            end
            ST_PAUSE: begin
                if (clr_p) begin
                    state_next = ST_IDLE;
                    zero_all   = 1'b1;
                end else if (ss_p) begin
                    state_next = ST_RUN;
                end
            end
`ifdef STOPWATCH_LAP_EN
            ST_LAP: begin
                if (ss_p) begin
                    state_next = ST_PAUSE;
                end else if (lap_p) begin
                    state_next = ST_RUN;
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
                zero_all   = 1'b1;
            end
        endcase
    end

    // The prescaler only advances while we stay in a counting state, so the
    // edge that pauses freezes it and the edge that resumes does not skip it.
    assign presc_en = is_counting(state) && is_counting(state_next);
    assign tick     = presc_en && (presc == PW'(DIV - 1));

    // Tick prescaler: 0..DIV-1 while counting, held in PAUSE, zeroed on clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (zero_all) begin
            presc <= '0;
        end else if (presc_en) begin
            presc <= tick ? '0 : presc + PW'(1);
        end
    end

    bcd_digit #(.MAX(DIGIT_MAX_DEC)) u_cs_u (
        .clk(clk), .rst_n(rst_n), .inc(tick), .clr(zero_all),
        .q_next(count_next[3:0]), .carry(c_cs_u)
    );
    bcd_digit #(.MAX(DIGIT_MAX_DEC)) u_cs_t (
        .clk(clk), .rst_n(rst_n), .inc(c_cs_u), .clr(zero_all),
        .q_next(count_next[7:4]), .carry(c_cs_t)
    );
    bcd_digit #(.MAX(DIGIT_MAX_DEC)) u_sec_u (
        .clk(clk), .rst_n(rst_n), .inc(c_cs_t), .clr(zero_all),
        .q_next(count_next[11:8]), .carry(c_sec_u)
    );
    bcd_digit #(.MAX(DIGIT_MAX_SEX)) u_sec_t (
        .clk(clk), .rst_n(rst_n), .inc(c_sec_u), .clr(zero_all),
        .q_next(count_next[15:12]), .carry(c_sec_t)
    );
    bcd_digit #(.MAX(DIGIT_MAX_DEC)) u_min_u (
        .clk(clk), .rst_n(rst_n), .inc(c_sec_t), .clr(zero_all),
        .q_next(count_next[19:16]), .carry(c_min_u)
    );
    bcd_digit #(.MAX(DIGIT_MAX_SEX)) u_min_t (
        .clk(clk), .rst_n(rst_n), .inc(c_min_u), .clr(zero_all),
        .q_next(count_next[23:20]), .carry(c_min_t)
    );

`ifdef STOPWATCH_LAP_EN
    logic [TIME_W-1:0] lap_q;
    logic              lap_active_q;

    // Lap register: captures the live count as it stands after this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_q <= '0;
        end else if (zero_all) begin
            lap_q <= '0;
        end else if (lap_take) begin
            lap_q <= count_next;
        end
    end

    // Lap indicator follows the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_active_q <= 1'b0;
        end else begin
            lap_active_q <= (state_next == ST_LAP);
        end
    end

    assign lap_active = lap_active_q;
    assign disp_src   = ((state_next == ST_LAP) && !lap_take) ? lap_q : count_next;
`else
    logic lap_p_unused;
    assign lap_p_unused = lap_p;
    assign lap_active   = 1'b0;
    assign disp_src     = count_next;
`endif

    // State register and registered outputs, all reflecting the new state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            running  <= 1'b0;
            ovf      <= 1'b0;
            disp_bcd <= '0;
        end else begin
            state    <= state_next;
            running  <= is_counting(state_next);
            ovf      <= c_min_t;
            disp_bcd <= disp_src;
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed and randomized checks of stopwatch_ctrl at
// CLK_HZ=1000, TICK_HZ=100 against an integer-centisecond reference model.
module tb_stopwatch_ctrl;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    localparam int DIV      = 10;
    localparam int FULL_CS  = 360000;
    localparam int S_IDLE   = 0;
    localparam int S_RUN    = 1;
    localparam int S_PAUSE  = 2;
    localparam int S_LAP    = 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        ss_p  = 1'b0;
    logic        clr_p = 1'b0;
    logic        lap_p = 1'b0;
    logic [23:0] disp_bcd;
    logic        running;
    logic        lap_active;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    int m_state;
    int m_presc;
    int m_cnt;
    int m_lap;
    bit m_ovf;

    stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
        .clk(clk), .rst_n(rst_n), .ss_p(ss_p), .clr_p(clr_p), .lap_p(lap_p),
        .disp_bcd(disp_bcd), .running(running), .lap_active(lap_active), .ovf(ovf)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Centisecond total to packed MM:SS.cc BCD.
    function automatic logic [23:0] to_bcd(input int cs);
        int mins;
        int secs;
        int c;
        mins = cs / 6000;
        secs = (cs / 100) % 60;
        c    = cs % 100;
        return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10),
                4'(c / 10), 4'(c % 10)};
    endfunction

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_state = S_IDLE;
        m_presc = 0;
        m_cnt   = 0;
        m_lap   = 0;
        m_ovf   = 1'b0;
    endtask

    // Reference behaviour for one rising edge with the given pulses.
    task automatic modelEdge(input bit ss, input bit clr, input bit lap);
        int  nst;
        bit  zero;
        bit  take;
        bit  was_counting;
        bit  will_count;
        nst  = m_state;
        zero = 1'b0;
        take = 1'b0;
        if (m_state == S_IDLE) begin
            if (clr) zero = 1'b1;
            else if (ss) nst = S_RUN;
        end else if (m_state == S_RUN) begin
            if (ss) nst = S_PAUSE;
            else if (lap && LAP_EN) begin nst = S_LAP; take = 1'b1; end
        end else if (m_state == S_PAUSE) begin
            if (clr) begin nst = S_IDLE; zero = 1'b1; end
            else if (ss) nst = S_RUN;
        end else begin
            if (ss) nst = S_PAUSE;
            else if (lap) nst = S_RUN;
        end
        was_counting = (m_state == S_RUN) || (m_state == S_LAP);
        will_count   = (nst == S_RUN) || (nst == S_LAP);
        m_ovf = 1'b0;
        if (zero) begin
            m_cnt   = 0;
            m_presc = 0;
            m_lap   = 0;
        end else if (was_counting && will_count) begin
            if (m_presc == DIV - 1) begin
                m_presc = 0;
                m_cnt   = m_cnt + 1;
                if (m_cnt == FULL_CS) begin
                    m_cnt = 0;
                    m_ovf = 1'b1;
                end
            end else begin
                m_presc = m_presc + 1;
            end
        end
        if (take) m_lap = m_cnt;
        m_state = nst;
    endtask

    task automatic checkAll();
        checkOutput("disp_bcd", 32'(disp_bcd), 32'(to_bcd(m_state == S_LAP ? m_lap : m_cnt)));
        checkOutput("running", 32'(running), 32'((m_state == S_RUN) || (m_state == S_LAP)));
        checkOutput("lap_active", 32'(lap_active), 32'(m_state == S_LAP));
        checkOutput("ovf", 32'(ovf), 32'(m_ovf));
    endtask

    // Drive pulses for one cycle, let the edge happen, then compare.
    task automatic applyStimulus(input bit ss, input bit clr, input bit lap);
        ss_p  = ss;
        clr_p = clr;
        lap_p = lap;
        @(posedge clk);
        #1;
        ss_p  = 1'b0;
        clr_p = 1'b0;
        lap_p = 1'b0;
        modelEdge(ss, clr, lap);
        checkAll();
    endtask

    task automatic checkZeroOutputs(input string tag);
        checkOutput({tag, "_disp"}, 32'(disp_bcd), 32'd0);
        checkOutput({tag, "_running"}, 32'(running), 32'd0);
        checkOutput({tag, "_lap_active"}, 32'(lap_active), 32'd0);
        checkOutput({tag, "_ovf"}, 32'(ovf), 32'd0);
    endtask

    task automatic checkBound(input string tag, input int used, input int limit);
        checkOutput(tag, 32'(used < limit), 32'd1);
    endtask

    initial begin
        int guard;
        modelReset();

        // Reset state.
        #22;
        checkZeroOutputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(0, 0, 0);

        // Start and run 250 cycles: 0.25 s.
        applyStimulus(1, 0, 0);
        for (int i = 0; i < 250; i++) applyStimulus(0, 0, 0);
        checkOutput("run250_disp", 32'(disp_bcd), 32'h000025);
        checkOutput("run250_running", 32'(running), 32'd1);

        // Pause with prescaler at 4, hold 100 cycles, resume.
        guard = 0;
        while (m_presc != 4 && guard < 50) begin
            applyStimulus(0, 0, 0);
            guard++;
        end
        checkBound("reach_presc4", guard, 50);
        applyStimulus(1, 0, 0);
        for (int i = 0; i < 100; i++) applyStimulus(0, 0, 0);
        checkOutput("pause_frozen", 32'(disp_bcd), 32'h000025);
        checkOutput("pause_running", 32'(running), 32'd0);
        applyStimulus(1, 0, 0);
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(0, 0, 0);
            checkOutput("resume_tick", 32'(disp_bcd), (i < 6) ? 32'h000025 : 32'h000026);
        end

        // Lap hold at 00:01.00.
        guard = 0;
        while (!(m_cnt == 100 && m_presc == 0) && guard < 2000) begin
            applyStimulus(0, 0, 0);
            guard++;
        end
        checkBound("reach_1s", guard, 2000);
        applyStimulus(0, 0, 1);
        for (int i = 0; i < 50; i++) applyStimulus(0, 0, 0);
        checkOutput("lap_hold_disp", 32'(disp_bcd), LAP_EN ? 32'h000100 : 32'h000105);
        checkOutput("lap_hold_active", 32'(lap_active), 32'(LAP_EN));
        applyStimulus(0, 0, 1);
        checkOutput("lap_release_disp", 32'(disp_bcd), 32'h000105);
        checkOutput("lap_release_active", 32'(lap_active), 32'd0);

        // Pulse priority: clr+ss in PAUSE, clr+lap in RUN.
        applyStimulus(1, 0, 0);
        applyStimulus(1, 1, 0);
        checkOutput("pause_clr_disp", 32'(disp_bcd), 32'd0);
        checkOutput("pause_clr_running", 32'(running), 32'd0);
        applyStimulus(1, 0, 0);
        for (int i = 0; i < 23; i++) applyStimulus(0, 0, 0);
        applyStimulus(0, 1, 1);
        checkOutput("run_clrlap_disp", 32'(disp_bcd), 32'h000002);
        checkOutput("run_clrlap_active", 32'(lap_active), 32'(LAP_EN));
        checkOutput("run_clrlap_running", 32'(running), 32'd1);

        // Wrap from 59:59.99.
        if (m_state == S_LAP) applyStimulus(0, 0, 1);
        force dut.u_min_t.q = 4'd5;
        force dut.u_min_u.q = 4'd9;
        force dut.u_sec_t.q = 4'd5;
        force dut.u_sec_u.q = 4'd9;
        force dut.u_cs_t.q  = 4'd9;
        force dut.u_cs_u.q  = 4'd9;
        #1;
        release dut.u_min_t.q;
        release dut.u_min_u.q;
        release dut.u_sec_t.q;
        release dut.u_sec_u.q;
        release dut.u_cs_t.q;
        release dut.u_cs_u.q;
        m_cnt = FULL_CS - 1;
        guard = 0;
        while (!m_ovf && guard < 12) begin
            applyStimulus(0, 0, 0);
            guard++;
        end
        checkBound("reach_wrap", guard, 12);
        checkOutput("wrap_disp", 32'(disp_bcd), 32'd0);
        checkOutput("wrap_ovf", 32'(ovf), 32'd1);
        checkOutput("wrap_running", 32'(running), 32'd1);
        applyStimulus(0, 0, 0);
        checkOutput("wrap_ovf_drop", 32'(ovf), 32'd0);

        // Randomized pulse traffic.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 25) == 0,
                          $urandom_range(0, 15) == 0);
        end

        // Asynchronous reset in the middle of a lap.
        if (m_state == S_IDLE || m_state == S_PAUSE) applyStimulus(1, 0, 0);
        if (m_state == S_RUN) applyStimulus(0, 0, 1);
        for (int i = 0; i < 37; i++) applyStimulus(0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkZeroOutputs("async_rst");
        ss_p  = 1'b1;
        lap_p = 1'b1;
        @(posedge clk);
        #1;
        checkZeroOutputs("rst_hold");
        ss_p  = 1'b0;
        lap_p = 1'b0;
        rst_n = 1'b1;
        modelReset();
        applyStimulus(0, 0, 0);

        $display("[TB] directed and random sequence complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
